// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpDiv = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } alu_state_e;

  // Bit positions inside the 4-bit flags word {Z, N, C, V}
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FlagZ] = z;
    f[FlagN] = n;
    f[FlagC] = c;
    f[FlagV] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative signed multiply / restoring divide, one bit per step on magnitudes.
// o_result reflects the state *after* the step taken this cycle, so the owner
// can register it on the final step edge.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_ovf
);

  logic               r_is_div;
  logic               r_neg_q;   // sign of product / quotient
  logic               r_neg_r;   // sign of remainder (dividend sign)
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_q;       // multiplier bits or dividend/quotient bits
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_mb;      // divisor magnitude

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_q_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remv;
  logic [WIDTH:0]     w_prod_top;

  // Operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    w_mag_a     = i_a[WIDTH-1] ? -i_a : i_a;
    w_mag_b     = i_b[WIDTH-1] ? -i_b : i_b;
    w_acc_nxt   = r_q[0] ? (r_acc + r_mcand) : r_acc;
    w_rem_sh    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    w_ge        = (w_rem_sh >= {1'b0, r_mb});
    w_rem_nxt   = w_ge ? (w_rem_sh - {1'b0, r_mb}) : w_rem_sh;
    w_q_div_nxt = {r_q[WIDTH-2:0], w_ge};
  end

  // Sign correction and overflow detection on the post-step values
  always_comb begin
    w_prod     = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_quo      = r_neg_q ? -w_q_div_nxt : w_q_div_nxt;
    w_remv     = r_neg_r ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0];
    w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
    if (r_is_div) begin
      o_result = {w_remv, w_quo};
      // Only most-negative / -1 yields a positive quotient magnitude of 2^(W-1)
      o_ovf    = ~r_neg_q & w_q_div_nxt[WIDTH-1];
    end else begin
      o_result = w_prod;
      o_ovf    = ~((&w_prod_top) | ~(|w_prod_top));
    end
  end

  // Operand load on start, one iteration per step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_mb     <= '0;
    end else if (i_start) begin
      r_is_div <= i_is_div;
      r_neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_neg_r  <= i_a[WIDTH-1];
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_q      <= i_is_div ? w_mag_a : w_mag_b;
      r_rem    <= '0;
      r_mb     <= w_mag_b;
    end else if (i_step) begin
      if (r_is_div) begin
        r_rem <= w_rem_nxt;
        r_q   <= w_q_div_nxt;
      end else begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_q     <= r_q >> 1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB, WIDTH-cycle iterative MULT/DIV.
// Owns the IDLE/RUN/DONE FSM, the adder and flag generation.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [1:0]         alu_operation,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic [3:0]         flags,
  output logic               busy,
  output logic               done
);

  localparam int unsigned    CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  alu_state_e         r_state;
  alu_op_e            r_op;
  logic [CntW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_result;
  logic [3:0]         r_flags;
  logic               r_busy;
  logic               r_done;

  alu_op_e            w_op;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_sum_lo;
  logic               w_add_v;
  logic               w_div_zero;
  logic               w_md_start;
  logic               w_md_step;
  logic [2*WIDTH-1:0] w_md_result;
  logic [WIDTH-1:0]   w_md_lo;
  logic               w_md_ovf;
  logic               w_md_z;
  logic               w_md_n;

  // Adder path, accept decode and mul/div flag derivation
  always_comb begin
    w_op       = alu_op_e'(alu_operation);
    w_sub      = (w_op == OpSub);
    w_b_eff    = w_sub ? ~operand_b : operand_b;
    w_sum      = {1'b0, operand_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    w_sum_lo   = w_sum[WIDTH-1:0];
    w_add_v    = (operand_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                 (w_sum_lo[WIDTH-1] != operand_a[WIDTH-1]);
    w_div_zero = (w_op == OpDiv) && (operand_b == '0);
    w_md_start = (r_state == StIdle) && ENABLE && w_op[1] && !w_div_zero;
    w_md_step  = (r_state == StRun);
    w_md_lo    = w_md_result[WIDTH-1:0];
    // MULT flags see the full product; DIV flags see the quotient only
    if (r_op == OpMul) begin
      w_md_z = ~(|w_md_result);
      w_md_n = w_md_result[2*WIDTH-1];
    end else begin
      w_md_z = ~(|w_md_lo);
      w_md_n = w_md_lo[WIDTH-1];
    end
  end

  alu_muldiv_unit #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .i_clk    (CLK),
    .i_rst_n  (RESET),
    .i_start  (w_md_start),
    .i_step   (w_md_step),
    .i_is_div (w_op == OpDiv),
    .i_a      (operand_a),
    .i_b      (operand_b),
    .o_result (w_md_result),
    .o_ovf    (w_md_ovf)
  );

  // Control FSM with registered result, flags, busy and done
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= StIdle;
      r_op     <= OpAdd;
      r_count  <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (ENABLE) begin
            r_busy  <= 1'b1;
            r_op    <= w_op;
            r_count <= '0;
            if (!w_op[1]) begin
              r_result <= {{WIDTH{w_sum_lo[WIDTH-1]}}, w_sum_lo};
              r_flags  <= pack_flags(~(|w_sum_lo), w_sum_lo[WIDTH-1], w_sum[WIDTH], w_add_v);
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else if (w_div_zero) begin
              // Quotient all ones is negative and non-zero
              r_result <= {operand_a, {WIDTH{1'b1}}};
              r_flags  <= pack_flags(1'b0, 1'b1, 1'b0, 1'b1);
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (r_count == LastIter) begin
            r_result <= w_md_result;
            r_flags  <= pack_flags(w_md_z, w_md_n, 1'b0, w_md_ovf);
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_count <= r_count + CntW'(1);
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_count <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign result    = r_result;
  assign flags     = r_flags;
  assign carry_out = r_flags[FlagC];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
